// File: rtl/mem_stage_pkg.sv
// Shared encodings and byte-lane helpers for the MEM stage.
// Helpers work on up to 8 byte lanes so both XLEN=32 and XLEN=64 can use them.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Low-address mask of an access: 0, 1, 3 or 7.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

    // Doubleword accesses only exist on a 64-bit datapath.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size,
                                        input logic is64);
        return ((off & size_mask(size)) != 3'd0) || (size == SZ_D && !is64);
    endfunction

    // Byte lane whose store data lands in `lane` once the item is replicated.
    function automatic logic [2:0] lane_src(input logic [2:0] lane, input logic [1:0] size);
        return lane & size_mask(size);
    endfunction

    // True when `lane` lies inside the access window [off, off + 2^size).
    function automatic logic lane_en(input logic [2:0] lane, input logic [2:0] off,
                                     input logic [1:0] size);
        return ({1'b0, lane} >= {1'b0, off}) &&
               ({1'b0, lane} < ({1'b0, off} + (4'd1 << size)));
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: shift the addressed item down to bit 0,
// then zero- or sign-extend it to the full datapath width.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_off,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_mask;
    logic            w_sign;

    always_comb begin
        w_sh = i_rdata >> {i_off, 3'b000};
        case (i_size)
            SZ_B: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_sh[7];
            end
            SZ_H: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_sh[15];
            end
            SZ_W: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_sh[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
        o_data = (w_sh & w_mask) | ((w_sign && !i_unsigned) ? ~w_mask : '0);
    end

endmodule

// File: rtl/memory_stage_pl.sv
// Pipelined MEM stage: drives a req/gnt/rvalid data-memory port, stalls the
// upstream stages while an access is in flight and fills the MEM/WB register.
module memory_stage_pl
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              memread_m,
    input  logic              memwrite_m,
    input  logic              regwrite_m,
    input  logic              isload_m,
    input  logic              unsigned_m,
    input  logic [1:0]        size_m,
    input  logic [XLEN-1:0]   aluresult_m,
    input  logic [XLEN-1:0]   writedata_m,
    input  logic [XLEN-1:0]   pcplus4_m,
    input  logic [RW-1:0]     rd_m,
    output logic              stall_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              valid_w,
    output logic              regwrite_w,
    output logic              isload_w,
    output logic              misalign_w,
    output logic              buserr_w,
    output logic [XLEN-1:0]   pcplus4_w,
    output logic [XLEN-1:0]   aluresult_w,
    output logic [XLEN-1:0]   readdata_w,
    output logic [RW-1:0]     rd_w
);

    localparam int   NB   = XLEN / 8;
    localparam int   OFFW = $clog2(NB);
    localparam logic IS64 = (XLEN == 64);

    state_e          r_state, w_state_nxt;
    logic [7:0]      r_cnt;
    logic [XLEN-1:0] r_addr, r_wdata, r_pcplus4;
    logic [1:0]      r_size;
    logic [RW-1:0]   r_rd;
    logic            r_unsigned, r_store, r_regwrite, r_isload;

    logic            w_memop, w_mis, w_accept, w_tick_to;
    logic            w_gnt_done, w_rsp_done, w_abort, w_retire;
    logic [2:0]      w_in_off, w_off;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_rep, w_load;

    assign w_in_off   = 3'(aluresult_m[OFFW-1:0]);
    assign w_off      = 3'(r_addr[OFFW-1:0]);
    assign w_memop    = valid_m && (memread_m || memwrite_m);
    assign w_mis      = misaligned(w_in_off, size_m, IS64);
    assign w_accept   = (r_state == ST_IDLE) && w_memop && !w_mis;
    assign w_tick_to  = (r_cnt + 8'd1) == 8'(TIMEOUT);
    assign w_gnt_done = (r_state == ST_REQ) && dmem_gnt;
    assign w_rsp_done = (r_state == ST_RESP) && dmem_rvalid;
    assign w_abort    = w_tick_to && (((r_state == ST_REQ) && !dmem_gnt) ||
                                      ((r_state == ST_RESP) && !dmem_rvalid));
    assign w_retire   = (w_gnt_done && r_store) || w_rsp_done || w_abort;

    always_ff @(posedge clock) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (dmem_gnt)     w_state_nxt = r_store ? ST_IDLE : ST_RESP;
                else if (w_abort) w_state_nxt = ST_IDLE;
            end
            ST_RESP: if (dmem_rvalid || w_abort) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Port signals are only non-zero while a request is actually on the bus.
    always_comb begin
        stall_m    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: stall_m = w_accept;
                ST_REQ: begin
                    stall_m    = !(dmem_gnt && r_store) && !w_abort;
                    dmem_req   = 1'b1;
                    dmem_we    = r_store;
                    dmem_addr  = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    dmem_wdata = w_rep;
                    dmem_be    = w_be;
                end
                ST_RESP: stall_m = !dmem_rvalid && !w_abort;
                default: stall_m = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_be  = '0;
        w_rep = '0;
        for (int i = 0; i < NB; i++) begin
            w_be[i]        = lane_en(3'(i), w_off, r_size);
            w_rep[i*8 +: 8] = r_wdata[8*lane_src(3'(i), r_size) +: 8];
        end
    end

    // Wait counter restarts on entry to REQ and again on entry to RESP.
    always_ff @(posedge clock) begin
        if (rst || w_accept || w_gnt_done) r_cnt <= '0;
        else if (r_state != ST_IDLE)      r_cnt <= r_cnt + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pcplus4  <= '0;
            r_size     <= '0;
            r_rd       <= '0;
            r_unsigned <= 1'b0;
            r_store    <= 1'b0;
            r_regwrite <= 1'b0;
            r_isload   <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= aluresult_m;
            r_wdata    <= writedata_m;
            r_pcplus4  <= pcplus4_m;
            r_size     <= size_m;
            r_rd       <= rd_m;
            r_unsigned <= unsigned_m;
            r_store    <= memwrite_m;
            r_regwrite <= regwrite_m;
            r_isload   <= isload_m;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata   (dmem_rdata),
        .i_off     (w_off),
        .i_size    (r_size),
        .i_unsigned(r_unsigned),
        .o_data    (w_load)
    );

    // Default is a bubble; a retirement overrides it. Data fields hold otherwise.
    always_ff @(posedge clock) begin
        if (rst) begin
            valid_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            isload_w    <= 1'b0;
            misalign_w  <= 1'b0;
            buserr_w    <= 1'b0;
            pcplus4_w   <= '0;
            aluresult_w <= '0;
            readdata_w  <= '0;
            rd_w        <= '0;
        end else begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
            misalign_w <= 1'b0;
            buserr_w   <= 1'b0;
            if ((r_state == ST_IDLE) && valid_m && !w_accept) begin
                valid_w     <= 1'b1;
                regwrite_w  <= regwrite_m && !w_memop;
                misalign_w  <= w_memop;
                isload_w    <= isload_m;
                rd_w        <= rd_m;
                pcplus4_w   <= pcplus4_m;
                aluresult_w <= aluresult_m;
            end else if (w_retire) begin
                valid_w     <= 1'b1;
                regwrite_w  <= r_regwrite && !w_abort;
                buserr_w    <= w_abort;
                isload_w    <= r_isload;
                rd_w        <= r_rd;
                pcplus4_w   <= r_pcplus4;
                aluresult_w <= r_addr;
                if (w_rsp_done) readdata_w <= w_load;
            end
        end
    end

endmodule

// File: doc/memory_stage_pl.md
MEMORY_STAGE_PL -- requirements
Module: memory_stage_pl

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 or 64.
REQ-002 Parameter RW, default 5: register-index width.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for dmem_gnt or dmem_rvalid before a bus error is raised.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 valid_m, memread_m, memwrite_m, regwrite_m, isload_m, unsigned_m  in  1 each  MEM-stage qualifiers.
REQ-007 size_m  in  2  access size: 00 byte, 01 half, 10 word, 11 double (64-bit only).
REQ-008 aluresult_m, writedata_m, pcplus4_m  in  XLEN  byte address, store data and PC+4.
REQ-009 rd_m  in  RW  destination register.
REQ-010 stall_m  out  1  holds all upstream stages.
REQ-011 dmem_req, dmem_we  out  1  memory request and write enable.
REQ-012 dmem_addr  out  XLEN  address aligned to XLEN/8 bytes.
REQ-013 dmem_wdata  out  XLEN  lane-replicated store data.
REQ-014 dmem_be  out  XLEN/8  byte enables.
REQ-015 dmem_gnt, dmem_rvalid  in  1  request accepted and read data valid.
REQ-016 dmem_rdata  in  XLEN  read data.
REQ-017 valid_w, regwrite_w, isload_w, misalign_w, buserr_w  out  1  WB qualifiers and fault flags.
REQ-018 pcplus4_w, aluresult_w, readdata_w  out  XLEN;  rd_w  out  RW  MEM/WB register contents.

Function
REQ-019 The FSM SHALL have states IDLE, REQ and RESP.
REQ-020 IDLE: valid_m with memread_m or memwrite_m, and an aligned access, SHALL move to REQ, assert stall_m and register all inputs.
REQ-021 REQ: dmem_req SHALL stay high with stable address, data and byte enables until dmem_gnt. On grant, a store returns to IDLE and a load moves to RESP.
REQ-022 RESP: on dmem_rvalid the FSM SHALL return to IDLE. dmem_rvalid is never sampled in the grant cycle.
REQ-023 stall_m SHALL be high in REQ and RESP, and low in the completion cycle (store grant or load rvalid).
REQ-024 The MEM/WB register SHALL capture on completion or on a non-memory valid_m in IDLE. Every other cycle it loads valid_w=0 and regwrite_w=0 (bubble).
REQ-025 Load data SHALL be shifted down by addr[log2(XLEN/8)-1:0]×8 and truncated to the access size. It is zero-extended if unsigned_m=1, otherwise sign-extended to XLEN.
REQ-026 Store data SHALL be replicated across lanes. dmem_be SHALL have exactly 2^size_m consecutive bits set, starting at the byte offset.
REQ-027 A misaligned access (address not a multiple of 2^size_m), or size 11 with XLEN=32, SHALL issue no request. It retires next cycle with misalign_w=1, valid_w=1 and regwrite_w=0.
REQ-028 An 8-bit wait counter (cleared on entry to REQ and to RESP) that reaches TIMEOUT SHALL abort to IDLE. The op retires with buserr_w=1 and regwrite_w=0.
REQ-029 An op that is neither read nor write SHALL pass through with 1-cycle latency. A memory op SHALL take ≥2 cycles, with a 2-cycle minimum for a store granted immediately.
REQ-030 memread_m and memwrite_m both high SHALL be treated as a store.

Reset
REQ-031 On rst: FSM goes to IDLE. All outputs and registers go to 0, including stall_m, dmem_req and valid_w. The counter clears.
REQ-032 rst asserted in REQ or RESP SHALL abandon the transaction with no retirement. A late dmem_rvalid in IDLE SHALL be ignored.

Structure
REQ-033 Package mem_stage_pkg SHALL hold the size encodings, the FSM state enum and the lane-alignment functions.
REQ-034 Load extraction and extension SHALL live in sub-module load_align, which is purely combinational.

Verification
REQ-035 SW 0xDEADBEEF at 0x100, gnt on first cycle -> be=1111, stall_m high 1 cycle, valid_w one cycle after grant.
REQ-036 LB at 0x103, rdata=0x80FFFFFF, gnt delay 2, rvalid delay 3 -> readdata_w=0xFFFFFF80; LBU gives 0x00000080.
REQ-037 LH at 0x101 -> no dmem_req, misalign_w=1, regwrite_w=0 next cycle.
REQ-038 SH 0x1234 at 0x102 -> dmem_wdata=0x12341234, be=1100.
REQ-039 LW with gnt but no rvalid -> buserr_w=1 after TIMEOUT cycles in RESP, stall_m released.
REQ-040 rst mid-RESP, then rvalid -> no retirement, all outputs 0, FSM in IDLE.
